// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit: size codes, FSM states,
// byte-enable and alignment helpers.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Size code 11 falls through to the word case.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return ((size == SZ_HALF) && addr[0]) || (size[1] && (addr != 2'b00));
    endfunction
endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of a read word.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] word,
    input  logic [1:0]   addr,
    input  logic [1:0]   size,
    input  logic         is_unsigned,
    output logic [N-1:0] data
);
    logic [N-1:0] lane;

    always_comb begin
        lane = word >> {addr, 3'b000};
        case (size)
            SZ_BYTE: data = {{(N-8){~is_unsigned & lane[7]}}, lane[7:0]};
            SZ_HALF: data = {{(N-16){~is_unsigned & lane[15]}}, lane[15:0]};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: req/ack handshake with the data memory,
// store formatting, load alignment, pipeline stall and fault pulses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemReadInput,
    input  logic         MemWriteInput,
    input  logic [1:0]   MemSizeInput,
    input  logic         MemUnsignedInput,
    input  logic [N-1:0] ALUResultInput,
    input  logic [N-1:0] WriteDataInput,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [N-1:0] dmem_addr,
    output logic [3:0]   dmem_be,
    output logic [N-1:0] dmem_wdata,
    input  logic [N-1:0] dmem_rdata,
    input  logic         dmem_ack,
    output logic [N-1:0] ReadDataOutput,
    output logic         StallOutput,
    output logic         MisalignOutput,
    output logic         BusErrorOutput
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     rdata_q, rdata_d;
    logic             berr_q, berr_d;

    logic             req, mis, in_access;
    logic [3:0]       be;
    logic [N-1:0]     wdata, load_data;

    assign req       = MemReadInput | MemWriteInput;
    assign mis       = misaligned(MemSizeInput, ALUResultInput[1:0]);
    assign be        = byte_en(MemSizeInput, ALUResultInput[1:0]);
    assign in_access = (state_q == ST_ACCESS);

    always_comb begin
        case (MemSizeInput)
            SZ_BYTE: wdata = {(N/8){WriteDataInput[7:0]}};
            SZ_HALF: wdata = {(N/16){WriteDataInput[15:0]}};
            default: wdata = WriteDataInput;
        endcase
    end

    mem_load_align #(.N(N)) u_align (
        .word        (dmem_rdata),
        .addr        (ALUResultInput[1:0]),
        .size        (MemSizeInput),
        .is_unsigned (MemUnsignedInput),
        .data        (load_data)
    );

    // IDLE-cycle outputs are combinational from the inputs, so they are
    // gated with reset to stay quiet while reset is held.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        berr_d         = 1'b0;
        StallOutput    = 1'b0;
        MisalignOutput = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (mis) begin
                        MisalignOutput = reset;
                        rdata_d        = '0;
                    end else begin
                        StallOutput = reset;
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                    end
                end
            end
            ST_ACCESS: begin
                StallOutput = 1'b1;
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    if (MemReadInput) rdata_d = load_data;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
        end
    end

    // A load wins when both read and write are requested.
    assign dmem_req       = in_access;
    assign dmem_we        = in_access & MemWriteInput & ~MemReadInput;
    assign dmem_be        = in_access ? be : 4'b0000;
    assign dmem_addr      = in_access ? {ALUResultInput[N-1:2], 2'b00} : '0;
    assign dmem_wdata     = in_access ? wdata : '0;
    assign ReadDataOutput = rdata_q;
    assign BusErrorOutput = berr_q;
endmodule
